vga_fb_arbiter: RTL and testbench

Shares the single-port framebuffer RAM between the VGA scan-out path and the CPU. It prefetches display pixels in raster order into a small show-ahead FIFO that the VGA output stage drains one word per pixel clock. CPU read/write requests are served in the gaps. Display refill preempts the CPU whenever the FIFO level falls to a low-water mark. The block sits between the VGA timing/colour stage and the framebuffer RAM, and runs in the pixel clock domain.

---
 rtl/vga_fb_arbiter.sv | 157 +++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares the single-port framebuffer RAM between
// raster-order display prefetch (show-ahead FIFO) and CPU accesses.
module vga_fb_arbiter #(
   parameter int ADDR_W     = 19,
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 16,
   parameter int LOW_WATER  = 4,
   parameter int FB_WORDS   = 307200
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              frame_start,
   input  logic              pix_rd,
   output logic [DATA_W-1:0] pix_data,
   output logic              pix_valid,
   output logic              underflow,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int LVL_W  = CNT_W + 1;
   localparam int FCNT_W = $clog2(FB_WORDS + 1);

   localparam logic [LVL_W-1:0]  LW_L    = LVL_W'(LOW_WATER);
   localparam logic [LVL_W-1:0]  FULL_L  = LVL_W'(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_WORDS - 1);
   localparam logic [FCNT_W-1:0] FB_CNT  = FCNT_W'(FB_WORDS);

   typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

   state_t              state;
   logic [ADDR_W-1:0]   disp_addr;
   logic [FCNT_W-1:0]   issued;
   logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [CNT_W-1:0]    count;

   // pipeline tags: d* display read, c* cpu access, r* cpu read
   logic d1, d2, c1, c2, r1, r2;

   logic [LVL_W-1:0] level;
   logic fetching, urgent, cpu_busy;
   logic grant_cpu, grant_disp, push, pop;

   always_comb begin
      level = LVL_W'(count) + LVL_W'(d1) + LVL_W'(d2);
      fetching = (state == FETCH) && !frame_start;
      urgent = fetching && (level <= LW_L);
      // ack cycle still counts as busy so a held request waits one more
      cpu_busy = c1 || c2 || cpu_ack;
      grant_cpu = cpu_req && !cpu_busy && !urgent;
      grant_disp = fetching && !grant_cpu && (level < FULL_L);
      push = d2 && !frame_start;
      pop = pix_rd && (count != '0) && !frame_start;
   end

   assign pix_valid = (count != '0);
   assign pix_data  = pix_valid ? fifo_mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= mem_rdata;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         disp_addr <= '0;
         issued    <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         d1        <= 1'b0;
         d2        <= 1'b0;
         c1        <= 1'b0;
         c2        <= 1'b0;
         r1        <= 1'b0;
         r2        <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_ack   <= 1'b0;
         cpu_rdata <= '0;
         underflow <= 1'b0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (frame_start)
                  state <= FETCH;
            end
            FETCH: begin
               if (grant_disp && (issued + 1'b1 == FB_CNT))
                  state <= DONE;
            end
            default: state <= IDLE;
         endcase

         if (frame_start) begin
            disp_addr <= '0;
            issued    <= '0;
         end else if (grant_disp) begin
            issued    <= issued + 1'b1;
            disp_addr <= (disp_addr == FB_LAST) ? '0 : disp_addr + 1'b1;
         end

         mem_en    <= grant_cpu || grant_disp;
         mem_we    <= grant_cpu && cpu_we;
         mem_addr  <= grant_cpu ? cpu_addr : disp_addr;
         mem_wdata <= grant_cpu ? cpu_wdata : '0;

         // in-flight display data is dropped when a new frame starts
         d1 <= grant_disp;
         d2 <= d1 && !frame_start;
         c1 <= grant_cpu;
         c2 <= c1;
         r1 <= grant_cpu && !cpu_we;
         r2 <= r1;
         cpu_ack <= c2;
         if (c2 && r2)
            cpu_rdata <= mem_rdata;

         if (frame_start) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push)
               wr_ptr <= wr_ptr + 1'b1;
            if (pop)
               rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
               count <= count + 1'b1;
            else if (pop && !push)
               count <= count - 1'b1;
         end

         if (frame_start)
            underflow <= 1'b0;
         else if (pix_rd && (count == '0))
            underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed and randomized checks of the framebuffer
// arbiter against a pixel-stream / CPU memory model.
module tb_vga_fb_arbiter;

   localparam int FB = 20;
   localparam int LW = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        frame_start;
   logic        pix_rd;
   logic [15:0] pix_data;
   logic        pix_valid;
   logic        underflow;
   logic        cpu_req;
   logic        cpu_we;
   logic [18:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic        cpu_ack;
   logic [15:0] cpu_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [18:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;

   vga_fb_arbiter #(.FB_WORDS(FB)) dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
      .pix_rd(pix_rd), .pix_data(pix_data), .pix_valid(pix_valid),
      .underflow(underflow), .cpu_req(cpu_req), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
      .cpu_rdata(cpu_rdata), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] init_val(input int a);
      if (a == 32'h200)
         return 16'h0F0F;
      return 16'(32'h5A00 ^ (a * 37));
   endfunction

   // RAM: contents are init_val() until written
   logic [15:0] ram [1024];
   logic        wr_flag [1024] = '{default: 1'b0};
   logic [15:0] rdata_q = '0;
   assign mem_rdata = rdata_q;

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            ram[mem_addr[9:0]] <= mem_wdata;
            wr_flag[mem_addr[9:0]] <= 1'b1;
         end
         rdata_q <= wr_flag[mem_addr[9:0]] ? ram[mem_addr[9:0]]
                                           : init_val(int'(mem_addr));
      end
   end

   int compared = 0;
   int mismatched = 0;
   int cycles = 0;
   int pmode = 0;
   int idx = 0;
   int dreads = 0;
   bit uf_exp = 1'b0;
   logic [15:0] shadow [int];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // one clock; pixel-stream model before the edge, checks after it
   task automatic tick();
      if (pmode == 1)
         pix_rd = (idx < FB);
      else if (pmode == 2)
         pix_rd = (idx < FB) && ($urandom_range(0, 1) == 1);
      if (frame_start) begin
         idx = 0;
         uf_exp = 1'b0;
      end else if (pix_rd) begin
         if (idx < FB) begin
            chk("pix_valid", 32'(pix_valid), 1);
            chk("pix_data", 32'(pix_data), 32'(init_val(idx)));
            idx++;
         end else begin
            chk("pix_empty", 32'(pix_valid), 0);
            uf_exp = 1'b1;
         end
      end
      @(posedge clk);
      @(negedge clk);
      if (frame_start)
         dreads = 0;
      else if (mem_en === 1'b1 && mem_we === 1'b0 && mem_addr < FB)
         dreads++;
      chk("underflow", 32'(underflow), 32'(uf_exp));
      cycles++;
      if (cycles > 20000) begin
         $display("FAIL timeout: cycles %0d limit 20000", cycles);
         $fatal(1);
      end
   endtask

   task automatic cpu_op(input bit we, input int addr,
                         input logic [15:0] wd, output int lat);
      logic [15:0] exp;
      bit got;
      int n;
      exp = shadow.exists(addr) ? shadow[addr] : init_val(addr);
      cpu_we = we;
      cpu_addr = 19'(addr);
      cpu_wdata = wd;
      cpu_req = 1'b1;
      got = 1'b0;
      n = 0;
      while (!got && n < 30) begin
         tick();
         n++;
         if (cpu_ack === 1'b1)
            got = 1'b1;
      end
      cpu_req = 1'b0;
      chk("cpu_ack_seen", 32'(got), 1);
      lat = n - 1;
      chk("cpu_lat_bound", 32'(lat <= LW + 3), 1);
      if (we)
         shadow[addr] = wd;
      else
         chk("cpu_rdata", 32'(cpu_rdata), 32'(exp));
   endtask

   initial begin
      int lat;
      rst_n = 1'b0;
      frame_start = 1'b0;
      pix_rd = 1'b0;
      cpu_req = 1'b0;
      cpu_we = 1'b0;
      cpu_addr = '0;
      cpu_wdata = '0;

      // reset and idle: all outputs zero, no RAM traffic
      repeat (3) begin
         tick();
         chk("rst_out", {mem_en, mem_we, cpu_ack, pix_valid,
             underflow, |mem_addr, |mem_wdata, |pix_data,
             |cpu_rdata}, 0);
      end
      rst_n = 1'b1;
      repeat (20) begin
         tick();
         chk("idle_out", {mem_en, mem_we, cpu_ack, pix_valid,
             underflow, |mem_addr, |mem_wdata, |pix_data,
             |cpu_rdata}, 0);
      end

      // prefetch: 16 reads at 0..15 on consecutive cycles
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         tick();
         if (n <= 16) begin
            chk("pf_en", 32'(mem_en), 1);
            chk("pf_addr", 32'(mem_addr), 32'(n - 1));
         end else begin
            chk("pf_en_off", 32'(mem_en), 0);
         end
         if (n == 2)
            chk("pf_valid_c2", 32'(pix_valid), 0);
         if (n == 3) begin
            chk("pf_valid_c3", 32'(pix_valid), 1);
            chk("pf_head", 32'(pix_data), 32'(init_val(0)));
         end
      end

      // CPU write with FIFO full
      cpu_we = 1'b1;
      cpu_addr = 19'h100;
      cpu_wdata = 16'hABCD;
      cpu_req = 1'b1;
      tick();
      chk("wr_strobe", {mem_en, mem_we}, 2'b11);
      chk("wr_addr", 32'(mem_addr), 32'h100);
      chk("wr_data", 32'(mem_wdata), 32'hABCD);
      tick();
      chk("wr_ack_early", 32'(cpu_ack), 0);
      tick();
      chk("wr_ack", 32'(cpu_ack), 1);
      shadow[32'h100] = 16'hABCD;
      tick();
      chk("wr_ack_pulse", 32'(cpu_ack), 0);
      chk("wr_no_regrant", 32'(mem_en), 0);
      cpu_req = 1'b0;
      tick();
      cpu_op(1'b0, 32'h100, 16'h0, lat);
      chk("rd_lat", lat, 2);
      tick();

      // mid-frame restart with a display read and CPU read in flight
      pix_rd = 1'b1;
      cpu_we = 1'b0;
      cpu_addr = 19'h200;
      cpu_req = 1'b1;
      tick();
      chk("rs_cpu_grant", {mem_en, mem_we}, 2'b10);
      chk("rs_cpu_addr", 32'(mem_addr), 32'h200);
      pix_rd = 1'b0;
      tick();
      chk("rs_disp_en", {mem_en, mem_we}, 2'b10);
      chk("rs_disp_addr", 32'(mem_addr), 16);
      frame_start = 1'b1;
      tick();
      chk("rs_ack", 32'(cpu_ack), 1);
      chk("rs_rdata", 32'(cpu_rdata), 32'h0F0F);
      chk("rs_flushed", 32'(pix_valid), 0);
      frame_start = 1'b0;
      cpu_req = 1'b0;
      tick();
      chk("rs_addr0", {31'(mem_addr), mem_en}, 1);
      chk("rs_stale", 32'(pix_valid), 0);
      chk("rs_ack_pulse", 32'(cpu_ack), 0);
      tick();
      chk("rs_addr1", 32'(mem_addr), 1);
      tick();
      chk("rs_first", 32'(pix_valid), 1);
      chk("rs_first_data", 32'(pix_data), 32'(init_val(0)));

      // contention: continuous pix_rd, back-to-back CPU reads
      repeat (22) tick();
      pmode = 1;
      repeat (3) cpu_op(1'b0, 32'h200, 16'h0, lat);
      for (int i = 0; i < 60 && idx < FB; i++)
         tick();
      chk("drain", idx, FB);
      pmode = 0;
      pix_rd = 1'b0;
      repeat (4) tick();
      chk("eof_reads", dreads, FB);
      chk("eof_idle", 32'(mem_en), 0);
      chk("eof_empty", 32'(pix_valid), 0);

      // underflow after drain is sticky until frame_start
      pix_rd = 1'b1;
      tick();
      pix_rd = 1'b0;
      repeat (3) tick();
      chk("uf_sticky", 32'(underflow), 1);
      frame_start = 1'b1;
      pix_rd = 1'b1;
      tick();
      frame_start = 1'b0;
      pix_rd = 1'b0;
      chk("uf_clear", 32'(underflow), 0);

      // randomized frames with random pops and CPU traffic
      for (int f = 0; f < 4; f++) begin
         if (f > 0) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
         end
         repeat (8) tick();
         pmode = 2;
         for (int k = 0; k < 5; k++) begin
            repeat ($urandom_range(0, 3)) tick();
            cpu_op(1'(($urandom_range(0, 1))),
                   32'h100 + int'($urandom_range(0, 255)),
                   16'($urandom), lat);
         end
         for (int i = 0; i < 200 && idx < FB; i++)
            tick();
         chk("rnd_drain", idx, FB);
         pmode = 0;
         pix_rd = 1'b0;
         repeat (3) tick();
         chk("rnd_reads", dreads, FB);
         chk("rnd_idle", 32'(mem_en), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
